// File: rtl/inv_mix_column.sv
// AES InvMixColumns over a full 128-bit state, one column per cycle through a
// single shared column datapath, with a valid/ready handshake on both sides.
module inv_mix_column (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] data_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state;
   state_t       state_nxt;
   logic [1:0]   col;
   logic [127:0] work;
   logic [31:0]  col_in;
   logic [31:0]  col_out;
   logic         load;
   logic         step;

   // Multiply by 02 in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] d);
      return {d[6:0], 1'b0} ^ (d[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_col(input logic [31:0] c);
      logic [3:0][7:0] a;
      logic [3:0][7:0] m9;
      logic [3:0][7:0] mb;
      logic [3:0][7:0] md;
      logic [3:0][7:0] me;
      logic [7:0]      x2;
      logic [7:0]      x4;
      logic [7:0]      x8;
      logic [3:0][7:0] b;
      a = c;
      for (int i = 0; i < 4; i++) begin
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      b[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      b[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      b[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      b[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
      return b;
   endfunction

   assign col_in  = work[{col, 5'b0} +: 32];
   assign col_out = inv_col(col_in);

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can
      // leave it unassigned and infer a latch.
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               load      = 1'b1;
               state_nxt = CALC;
            end
         end
         CALC: begin
            step = 1'b1;
            if (col == 2'd3) state_nxt = DONE;
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The working register is cleared on reset so an aborted operation leaves
   // nothing visible on data_out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         col   <= 2'd0;
         work  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge
         // values regardless of statement order.
         state <= state_nxt;
         if (load) begin
            work <= data_in;
            col  <= 2'd0;
         end else if (step) begin
            work[{col, 5'b0} +: 32] <= col_out;
            col                     <= col + 2'd1;
         end
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign data_out  = work;

endmodule

// File: tb/tb_inv_mix_column.sv
// Self-checking bench for inv_mix_column: known vectors, backpressure, reset
// abort, and random round trips through a behavioural forward MixColumns.
module tb_inv_mix_column;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] data_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] data_out;
   logic         busy;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   inv_mix_column dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, got running want done");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   // Generic shift-and-add GF(2^8) product, modulus 0x11b.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   // Circulant-matrix column mix; row r uses coefficient k[(c - r) mod 4] for byte c.
   function automatic logic [127:0] mix_state(input logic [127:0] s, input logic [31:0] k);
      logic [127:0] o = '0;
      logic [7:0]   coef [4];
      logic [7:0]   acc;
      for (int i = 0; i < 4; i++) coef[i] = k[8*i +: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc ^= gmul(coef[(j - r + 4) % 4], s[32*c + 8*j +: 8]);
            o[32*c + 8*r +: 8] = acc;
         end
      return o;
   endfunction

   function automatic logic [127:0] fwd_mix(input logic [127:0] s);
      return mix_state(s, {8'h01, 8'h01, 8'h03, 8'h02});
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      return mix_state(s, {8'h09, 8'h0d, 8'h0b, 8'h0e});
   endfunction

   // Runs one full transaction from IDLE; holds DONE for 'hold' cycles first.
   task automatic do_op(input logic [127:0] x, input logic [127:0] exp,
                        input int hold, input bit toggle);
      check("in_ready_idle", {127'd0, in_ready}, 128'd1);
      in_valid  = 1'b1;
      data_in   = x;
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         if (e == 1) begin
            check("in_ready_calc", {127'd0, in_ready}, 128'd0);
            check("busy_calc", {127'd0, busy}, 128'd1);
         end
         if (e == 4) check("out_valid_early", {127'd0, out_valid}, 128'd0);
         if (toggle) begin
            in_valid = 1'($urandom);
            data_in  = {$urandom, $urandom, $urandom, $urandom};
         end
         @(posedge clk); #1;
      end
      if (toggle) begin
         in_valid = 1'b1;
         data_in  = {$urandom, $urandom, $urandom, $urandom};
      end
      check("out_valid_done", {127'd0, out_valid}, 128'd1);
      check("data_out", data_out, exp);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("hold_valid", {127'd0, out_valid}, 128'd1);
         check("hold_data", data_out, exp);
         check("hold_in_ready", {127'd0, in_ready}, 128'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("in_ready_after", {127'd0, in_ready}, 128'd1);
      check("out_valid_after", {127'd0, out_valid}, 128'd0);
      check("busy_after", {127'd0, busy}, 128'd0);
   endtask

   initial begin
      logic [127:0] x;
      logic [127:0] v1;
      logic [127:0] v1_exp;
      logic [127:0] v2;
      logic [127:0] v2_exp;
      v1     = {4{32'hbca14d8e}};
      v1_exp = {4{32'h455313db}};
      v2     = {32'hc6c6c6c6, 32'h01010101, 32'hd6d7d5d5, 32'h9d58dc9f};
      v2_exp = {32'hc6c6c6c6, 32'h01010101, 32'hd5d4d4d4, 32'h5c220af2};

      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      data_in   = '0;
      #12;
      check("rst_out_valid", {127'd0, out_valid}, 128'd0);
      check("rst_data_out", data_out, '0);
      check("rst_busy", {127'd0, busy}, 128'd0);
      check("rst_in_ready", {127'd0, in_ready}, 128'd1);
      rst = 1'b1;
      @(posedge clk); #1;

      // Sanity of the reference model itself against the published vectors.
      check("model_v1", inv_mix(v1), v1_exp);
      check("model_v2", inv_mix(v2), v2_exp);

      do_op(v1, v1_exp, 0, 1'b0);
      do_op(v2, v2_exp, 10, 1'b0);

      // Abort after two CALC edges; reset must act without a clock edge.
      in_valid = 1'b1;
      data_in  = v2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      #2 rst = 1'b0;
      #1;
      check("abort_out_valid", {127'd0, out_valid}, 128'd0);
      check("abort_data_out", data_out, '0);
      check("abort_in_ready", {127'd0, in_ready}, 128'd1);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      do_op(v1, v1_exp, 1, 1'b0);

      for (int n = 0; n < 1000; n++) begin
         x = {$urandom, $urandom, $urandom, $urandom};
         do_op(fwd_mix(x), x, $urandom_range(0, 2), 1'b1);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/inv_mix_column.md
INV_MIX_COLUMN -- requirements
Module: inv_mix_column

Interface
REQ-001 The block SHALL have no parameters; width is fixed at one 128-bit AES state.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; rst=0 SHALL force reset state immediately, independent of clk.
REQ-004 in_valid  input  1  data_in holds a state to be transformed.
REQ-005 in_ready  output  1  block can accept a state; SHALL equal 1 only in IDLE.
REQ-006 data_in  input  128  input state; column c = bits [32c+31:32c]; byte r of column c = bits [32c+8r+7:32c+8r].
REQ-007 out_valid  output  1  data_out holds a completed result.
REQ-008 out_ready  input  1  downstream accepts the result.
REQ-009 data_out  output  128  result state, same byte/column layout as data_in.
REQ-010 busy  output  1  SHALL equal 1 in CALC and DONE, 0 in IDLE.

Function
REQ-011 The block SHALL implement AES InvMixColumns per column (a0..a3 = bytes 0..3): b0=0e*a0^0b*a1^0d*a2^09*a3; b1=09*a0^0e*a1^0b*a2^0d*a3; b2=0d*a0^09*a1^0e*a2^0b*a3; b3=0b*a0^0d*a1^09*a2^0e*a3.
REQ-012 GF(2^8) multiplication SHALL use polynomial 0x11b; xtime(d) = (d<<1)&0xff, XOR 0x1b when d[7]=1; 09/0b/0d/0e products SHALL be built from xtime chains and XOR only, with no lookup tables.
REQ-013 The block SHALL be the exact inverse of the team's forward MixColumns with identical byte layout: InvMix(Mix(x)) = x for every 128-bit x.
REQ-014 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-015 IDLE: on a rising edge with in_valid=1, the block SHALL latch data_in into a 128-bit working register, clear the 2-bit column counter col, and enter CALC; with in_valid=0 it SHALL remain in IDLE.
REQ-016 CALC: each edge SHALL replace working column col with its InvMixColumns result and increment col; the edge that processes col=3 SHALL enter DONE and wrap col to 0.
REQ-017 Exactly one column SHALL be processed per cycle, in order 0,1,2,3; one shared column datapath SHALL serve all four columns.
REQ-018 out_valid SHALL be 1 only in DONE, first visible after the 5th rising edge counted from the accepting edge (accept edge plus 4 CALC edges).
REQ-019 DONE: data_out and out_valid SHALL hold stable while out_ready=0; an edge with out_ready=1 SHALL return the FSM to IDLE.
REQ-020 in_ready SHALL be 0 in CALC and DONE; in_valid asserted then SHALL be ignored, and data_in changes SHALL NOT affect the result in flight.
REQ-021 A state accepted in IDLE SHALL be processed even if in_valid drops the next cycle; in_valid=1 on the IDLE edge right after DONE SHALL start a new operation.
REQ-022 data_out SHALL be driven from the working register; its value is defined only while out_valid=1.
REQ-023 Maximum throughput SHALL be one state per 6 cycles: accept, 4 CALC, 1 DONE with out_ready=1.

Reset
REQ-024 rst=0 SHALL force state=IDLE, col=0, working register=0, and thus data_out=0, out_valid=0, busy=0, in_ready=1.
REQ-025 Reset asserted in CALC or DONE SHALL abort the operation with no partial result surviving; the first edge after rst=1 SHALL behave as IDLE.

Verification
REQ-026 Column vector: all four columns = 32'hbca14d8e -> after 5 edges, out_valid=1, data_out = four copies of 32'h455313db.
REQ-027 Mixed columns: col0=32'h9d58dc9f, col1=32'hd6d7d5d5, col2=32'h01010101, col3=32'hc6c6c6c6 -> col0=32'h5c220af2, col1=32'hd5d4d4d4, col2=32'h01010101, col3=32'hc6c6c6c6.
REQ-028 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and data_out stable, in_ready=0; out_ready=1 -> IDLE on that edge, in_ready=1 next cycle.
REQ-029 Reset mid-CALC: rst=0 after 2 CALC edges -> immediately out_valid=0, data_out=0, in_ready=1; the next accepted vector yields a correct result.
REQ-030 Round trip: 1000 random x through forward MixColumns then this block -> data_out == x every time; in_valid toggled during CALC -> no extra accepts.
